div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider for the execute stage; serves DIV/DIVU.
- Produces quotient (LO) and remainder (HI), and raises execute_pause to the pipeline stall controller while a division is in flight.
- Freezes PC through execute via the stall vector; releases the pipeline with a one-cycle ready pulse carrying the result.

---
 rtl/cpu_defs_pkg.sv | 29 ++
 rtl/div_step.sv | 33 +++
 rtl/div_unit.sv | 153 +++++++++++++++
 tb/tb_div_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs_pkg
//   Shared CPU definitions used by the execute-stage divider and its neighbours.
//   - div_state_t   : divider FSM state encoding
//   - DIV_CYCLES    : number of restoring iterations for a full-width divide
//   - stall_bit_e   : bit positions inside the pipeline stall vector
// -----------------------------------------------------------------------------
package cpu_defs_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      DIVZERO = 2'd2,
      DONE    = 2'd3
   } div_state_t;

   localparam int DIV_CYCLES = 32;

   // Stall vector layout: a set bit freezes that stage and everything before it.
   typedef enum logic [2:0] {
      STALL_PC  = 3'd0,
      STALL_IF  = 3'd1,
      STALL_ID  = 3'd2,
      STALL_EX  = 3'd3,
      STALL_MEM = 3'd4,
      STALL_WB  = 3'd5
   } stall_bit_e;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division step.
//   Ports:
//     rem      in  WIDTH  partial remainder before the step
//     dvd_bit  in  1      next dividend bit shifted into the remainder
//     divisor  in  WIDTH  divisor magnitude
//     rem_next out WIDTH  partial remainder after the step
//     q_bit    out 1      quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem < divisor on entry, so shifted <= 2*divisor-1: a successful trial
   // never reaches bit WIDTH, and a failed one always wraps into it.
   always_comb begin
      shifted  = {rem, dvd_bit};
      trial    = shifted - {1'b0, divisor};
      q_bit    = ~trial[WIDTH];
      rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Multi-cycle integer divider for DIV/DIVU in the execute stage.
//   Holds the pipeline with execute_pause while a divide is in flight and
//   releases it with a one-cycle ready pulse carrying quotient and remainder.
//   Ports:
//     clk            in  1      rising-edge clock
//     rst            in  1      synchronous active-low reset
//     start          in  1      DIV/DIVU present in execute
//     signed_op      in  1      1 = DIV (two's complement), 0 = DIVU
//     dividend       in  WIDTH  rs operand, sampled on accepted start
//     divisor        in  WIDTH  rt operand, sampled on accepted start
//     annul          in  1      cancel the in-flight instruction
//     execute_pause  out 1      stall request to the stall controller
//     ready          out 1      one-cycle result-valid pulse
//     result_lo      out WIDTH  quotient
//     result_hi      out WIDTH  remainder
// -----------------------------------------------------------------------------
module div_unit
   import cpu_defs_pkg::*;
#(
   parameter int WIDTH = DIV_CYCLES,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             annul,
   output logic             execute_pause,
   output logic             ready,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_q;     // partial remainder
   logic [WIDTH-1:0] dvd_q;     // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dsr_q;     // divisor magnitude
   logic             q_neg;
   logic             r_neg;

   logic [WIDTH-1:0] dividend_abs;
   logic [WIDTH-1:0] divisor_abs;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;
   logic [WIDTH-1:0] q_final;

   assign dividend_abs = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
   assign divisor_abs  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem      (rem_q),
      .dvd_bit  (dvd_q[WIDTH-1]),
      .divisor  (dsr_q),
      .rem_next (step_rem),
      .q_bit    (step_q)
   );

   assign q_final = {dvd_q[WIDTH-2:0], step_q};

   // The stall must assert in the very cycle start appears, so it cannot wait
   // for the state register.
   always_comb begin
      // NOTE: default assignment first so no path leaves the output unassigned (no latch).
      execute_pause = 1'b0;
      case (state)
         IDLE:          execute_pause = start & ~annul;
         BUSY, DIVZERO: execute_pause = 1'b1;
         default:       execute_pause = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: working registers are reset too, so a reset mid-divide leaves
         // no residue observable in a later operation.
         state     <= IDLE;
         cnt       <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         ready     <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !annul) begin
                  q_neg <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_neg <= signed_op & dividend[WIDTH-1];
                  dsr_q <= divisor_abs;
                  cnt   <= '0;
                  rem_q <= '0;
                  if (divisor == '0) begin
                     // Raw dividend is kept: it is returned unchanged in HI.
                     dvd_q <= dividend;
                     state <= DIVZERO;
                  end else begin
                     dvd_q <= dividend_abs;
                     state <= BUSY;
                  end
               end
            end

            BUSY: begin
               if (annul) begin
                  state <= IDLE;
               end else begin
                  rem_q <= step_rem;
                  dvd_q <= q_final;
                  cnt   <= cnt + CNT_W'(1);
                  if (cnt == LAST_CNT) begin
                     result_lo <= q_neg ? -q_final  : q_final;
                     result_hi <= r_neg ? -step_rem : step_rem;
                     ready     <= 1'b1;
                     state     <= DONE;
                  end
               end
            end

            DIVZERO: begin
               if (annul) begin
                  state <= IDLE;
               end else begin
                  result_lo <= '1;
                  result_hi <= dvd_q;
                  ready     <= 1'b1;
                  state     <= DONE;
               end
            end

            // Result already committed; annul here is too late to matter.
            DONE: state <= IDLE;

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//   Scoreboard bench for div_unit: expected results are queued when a divide
//   is launched and compared when ready pulses. Inputs change on the falling
//   edge; outputs are sampled 1 ns after the falling edge.
// -----------------------------------------------------------------------------
module tb_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         signed_op = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         annul = 1'b0;
   logic         execute_pause;
   logic         ready;
   logic [W-1:0] result_lo;
   logic [W-1:0] result_hi;

   typedef struct packed {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
   } res_t;

   res_t         exp_q[$];
   int           checks = 0;
   int           failures = 0;
   logic [W-1:0] last_lo = '0;
   logic [W-1:0] last_hi = '0;

   always #5 clk = ~clk;

   div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .signed_op     (signed_op),
      .dividend      (dividend),
      .divisor       (divisor),
      .annul         (annul),
      .execute_pause (execute_pause),
      .ready         (ready),
      .result_lo     (result_lo),
      .result_hi     (result_hi)
   );

   task automatic push_exp(input logic [W-1:0] lo, input logic [W-1:0] hi);
      res_t r;
      r.lo = lo;
      r.hi = hi;
      exp_q.push_back(r);
   endtask

   // Reference model: 64-bit host arithmetic, truncating division, wrap to W bits.
   task automatic push_model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t   r;
      longint la, lb, q, m;
      if (b == '0) begin
         r.lo = '1;
         r.hi = a;
      end else if (s) begin
         la   = longint'($signed(a));
         lb   = longint'($signed(b));
         q    = la / lb;
         m    = la % lb;
         r.lo = q[W-1:0];
         r.hi = m[W-1:0];
      end else begin
         r.lo = a / b;
         r.hi = a % b;
      end
      exp_q.push_back(r);
   endtask

   // Launch one divide at the next falling edge (cycle 0) and hold start until
   // ready. Leaves start high so a caller may chain another op immediately.
   task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_cyc, input string name);
      res_t e;
      int   cyc;
      int   pause_cnt;
      logic got;
      @(negedge clk);
      signed_op = s;
      dividend  = a;
      divisor   = b;
      annul     = 1'b0;
      start     = 1'b1;
      #1;
      cyc       = 0;
      pause_cnt = 0;
      got       = 1'b0;
      while (!got && cyc <= 200) begin
         if (execute_pause === 1'b1) pause_cnt++;
         if (ready === 1'b1) got = 1'b1;
         else begin
            @(negedge clk);
            #1;
            cyc++;
         end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL %s_timeout: no ready after %0d cycles, required ready in cycle %0d",
                  name, cyc, exp_cyc);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
         checks++;
         if (cyc != exp_cyc) begin
            failures++;
            $display("FAIL %s_latency: ready in cycle %0d, required %0d", name, cyc, exp_cyc);
         end
         checks++;
         if (pause_cnt != exp_cyc) begin
            failures++;
            $display("FAIL %s_pause: execute_pause high %0d cycles, required %0d",
                     name, pause_cnt, exp_cyc);
         end
         e = exp_q.pop_front();
         checks++;
         if (result_lo !== e.lo) begin
            failures++;
            $display("FAIL %s_lo: got 0x%08h, required 0x%08h", name, result_lo, e.lo);
         end
         checks++;
         if (result_hi !== e.hi) begin
            failures++;
            $display("FAIL %s_hi: got 0x%08h, required 0x%08h", name, result_hi, e.hi);
         end
         last_lo = e.lo;
         last_hi = e.hi;
      end
   endtask

   // Drop start after a completed op and confirm ready was a single-cycle pulse.
   task automatic go_idle(input int n);
      @(negedge clk);
      start = 1'b0;
      annul = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL ready_one_cycle: ready=%b after DONE, required 0", ready);
      end
      repeat (n) @(negedge clk);
   endtask

   // Watch for n cycles that no ready appears and results stay put.
   task automatic expect_quiet(input int n, input string name);
      int pulses;
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         if (ready === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL %s_no_ready: saw %0d ready pulses, required 0", name, pulses);
      end
      checks++;
      if (result_lo !== last_lo || result_hi !== last_hi) begin
         failures++;
         $display("FAIL %s_hold: lo/hi 0x%08h/0x%08h, required 0x%08h/0x%08h",
                  name, result_lo, result_hi, last_lo, last_hi);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (execute_pause !== 1'b0 || ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: pause=%b ready=%b, required 0/0", execute_pause, ready);
      end
      checks++;
      if (result_lo !== '0 || result_hi !== '0) begin
         failures++;
         $display("FAIL reset_results: lo/hi 0x%08h/0x%08h, required 0/0", result_lo, result_hi);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_unsigned();
      push_exp(32'd14, 32'd2);
      run_div(1'b0, 32'd100, 32'd7, 33, "divu_100_7");
      go_idle(2);
      push_exp(32'hFFFF_FFFF, 32'd0);
      run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 33, "divu_max_1");
      go_idle(2);
   endtask

   task automatic test_signed();
      push_exp(32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33, "div_m7_2");
      go_idle(2);
   endtask

   task automatic test_overflow();
      push_exp(32'h8000_0000, 32'd0);
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div_ovf");
      go_idle(2);
   endtask

   task automatic test_divzero();
      push_exp(32'hFFFF_FFFF, 32'h0000_1234);
      run_div(1'b0, 32'h0000_1234, 32'd0, 2, "divu_zero");
      go_idle(2);
   endtask

   task automatic test_back_to_back();
      push_exp(32'd10, 32'd0);
      push_exp(32'd2, 32'd1);
      run_div(1'b0, 32'd50, 32'd5, 33, "b2b_first");
      run_div(1'b0, 32'd9, 32'd4, 33, "b2b_second");
      go_idle(2);
   endtask

   task automatic test_random();
      logic         s;
      logic [W-1:0] a, b;
      for (int i = 0; i < 6; i++) begin
         s = 1'(i % 2);
         a = $urandom;
         b = (i == 2) ? 32'd3 : ($urandom >> (i * 4));
         if (b == '0) b = 32'd5;
         push_model(s, a, b);
         run_div(s, a, b, 33, "random");
         go_idle(1);
      end
   endtask

   task automatic test_annul_idle();
      @(negedge clk);
      signed_op = 1'b0;
      dividend  = 32'd77;
      divisor   = 32'd7;
      start     = 1'b1;
      annul     = 1'b1;
      #1;
      checks++;
      if (execute_pause !== 1'b0) begin
         failures++;
         $display("FAIL annul_idle_pause: pause=%b, required 0", execute_pause);
      end
      @(negedge clk);
      start = 1'b0;
      annul = 1'b0;
      expect_quiet(40, "annul_idle");
   endtask

   task automatic test_annul_busy();
      @(negedge clk);
      signed_op = 1'b0;
      dividend  = 32'd1000;
      divisor   = 32'd3;
      start     = 1'b1;
      annul     = 1'b0;
      repeat (10) @(negedge clk);
      annul = 1'b1;
      #1;
      checks++;
      if (execute_pause !== 1'b1) begin
         failures++;
         $display("FAIL annul_busy_pause_hold: pause=%b, required 1", execute_pause);
      end
      @(negedge clk);
      annul = 1'b0;
      start = 1'b0;
      #1;
      checks++;
      if (execute_pause !== 1'b0) begin
         failures++;
         $display("FAIL annul_busy_pause_drop: pause=%b, required 0", execute_pause);
      end
      expect_quiet(40, "annul_busy");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      signed_op = 1'b0;
      dividend  = 32'd1000;
      divisor   = 32'd3;
      start     = 1'b1;
      repeat (5) @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (execute_pause !== 1'b0 || ready !== 1'b0 || result_lo !== '0 || result_hi !== '0) begin
         failures++;
         $display("FAIL reset_mid: pause=%b ready=%b lo=0x%08h hi=0x%08h, required all 0",
                  execute_pause, ready, result_lo, result_hi);
      end
      rst     = 1'b1;
      last_lo = '0;
      last_hi = '0;
      expect_quiet(40, "reset_mid");
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_overflow();
      test_divzero();
      test_back_to_back();
      test_random();
      test_annul_idle();
      test_annul_busy();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
